// File: rtl/rv_pkg.sv
// Shared integer register file constants: default geometry, ABI register indices
// and the stack pointer reset value.
package rv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;

  localparam logic [63:0] SP_RESET = 64'd2048;

endpackage

// File: rtl/rf_busy_tracker.sv
// Per-register busy scoreboard: in-flight destination bits with same-cycle
// write-clear bypass onto rd_busy and iss_ready.
module rf_busy_tracker #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NWP  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*AW-1:0]   rd_addr,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  output logic              iss_ready,
  output logic [1:0]        rd_busy,
  output logic [NREG-1:0]   busy_vec
);
  import rv_pkg::*;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [AW-1:0]   src;

  // Clear vector from all write ports, then claim acceptance and next state.
  always_comb begin
    clr       = '0;
    set       = '0;
    iss_ready = 1'b0;
    rd_busy   = '0;
    src       = '0;
    busy_d    = busy_q;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (wr_en[p]) clr[wr_addr[p*AW +: AW]] = 1'b1;
    end
    iss_ready = (iss_dst == AW'(REG_ZERO)) | ~busy_q[iss_dst] | clr[iss_dst];
    if (iss_valid && iss_ready && (iss_dst != AW'(REG_ZERO))) set[iss_dst] = 1'b1;
    // Set is ORed after the clear so a same-cycle claim keeps the bit high.
    busy_d           = (busy_q & ~clr) | set;
    busy_d[REG_ZERO] = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      src        = rd_addr[p*AW +: AW];
      rd_busy[p] = busy_q[src] & ~clr[src];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file: two combinational read ports with write bypass,
// NWP write ports (highest index wins) and an in-flight destination scoreboard.
module rv_regfile_sb #(
  parameter int unsigned XLEN     = rv_pkg::XLEN,
  parameter int unsigned NREG     = rv_pkg::NREG,
  parameter int unsigned NWP      = 2,
  parameter logic [63:0] SP_RESET = rv_pkg::SP_RESET,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*AW-1:0]     rd_addr,
  output logic [2*XLEN-1:0]   rd_data,
  output logic [1:0]          rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_dst,
  output logic                iss_ready,
  output logic [NREG-1:0]     busy_vec
);
  import rv_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   raddr;
  logic [AW-1:0]   waddr;

  // Commit on the rising edge; later ports overwrite earlier ones on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= (i == REG_SP) ? XLEN'(SP_RESET) : '0;
      end
    end else begin
      for (int unsigned p = 0; p < NWP; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(REG_ZERO))) begin
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read mux: stored value, overridden by the highest enabled matching write port.
  always_comb begin
    rd_data = '0;
    raddr   = '0;
    waddr   = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      raddr = rd_addr[r*AW +: AW];
      if (raddr != AW'(REG_ZERO)) begin
        rd_data[r*XLEN +: XLEN] = regs[raddr];
        for (int unsigned p = 0; p < NWP; p++) begin
          waddr = wr_addr[p*AW +: AW];
          if (wr_en[p] && (waddr == raddr)) rd_data[r*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  rf_busy_tracker #(
    .NREG (NREG),
    .NWP  (NWP),
    .AW   (AW)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb: a register/busy-set model checked every
// cycle, plus literal expectations at the points the test plan names.
module tb_rv_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*AW-1:0]     rd_addr;
  logic [2*XLEN-1:0]   rd_data;
  logic [1:0]          rd_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_dst;
  logic                iss_ready;
  logic [NREG-1:0]     busy_vec;

  rv_regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_ready(iss_ready), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  bit              m_valid = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit written(input int r);
    for (int p = 0; p < NWP; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int r);
    logic [XLEN-1:0] v;
    if (r == 0) return '0;
    v = m_regs[r];
    for (int p = 0; p < NWP; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == r) v = wr_data[p*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_ready();
    int d = int'(iss_dst);
    return (d == 0) || !m_busy[d] || written(d);
  endfunction

  // Model update: writes land, their targets go idle, then an accepted claim sets busy.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = (i == 2) ? 64'd2048 : 64'd0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit claim;
      claim = iss_valid && exp_ready() && (iss_dst != 0);
      for (int p = 0; p < NWP; p++) begin
        if (wr_en[p]) begin
          if (wr_addr[p*AW +: AW] != 0) m_regs[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
          m_busy[wr_addr[p*AW +: AW]] = 1'b0;
        end
      end
      if (claim) m_busy[iss_dst] = 1'b1;
    end
  end

  // Compare every cycle outside reset once the model holds known state.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      logic [NREG-1:0] ev;
      for (int i = 0; i < NREG; i++) ev[i] = m_busy[i];
      for (int p = 0; p < 2; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        check($sformatf("model rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], exp_rd(a));
        check($sformatf("model rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(m_busy[a] && !written(a)));
      end
      check("model iss_ready", 64'(iss_ready), 64'(exp_ready()));
      check("model busy_vec", 64'(busy_vec), 64'(ev));
    end
  end

  task automatic drive(input int r0, input int r1, input logic [1:0] we,
                       input int a0, input int a1, input logic [XLEN-1:0] d0,
                       input logic [XLEN-1:0] d1, input logic iv, input int dst);
    rd_addr   = {AW'(r1), AW'(r0)};
    wr_en     = we;
    wr_addr   = {AW'(a1), AW'(a0)};
    wr_data   = {d1, d0};
    iss_valid = iv;
    iss_dst   = AW'(dst);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset contents
    drive(2, 5, 2'b00, 0, 0, '0, '0, 1'b0, 5);
    check("reset x2", rd_data[0 +: XLEN], 64'd2048);
    check("reset x5", rd_data[XLEN +: XLEN], 64'd0);
    check("reset busy_vec", 64'(busy_vec), 64'd0);
    check("reset iss_ready", 64'(iss_ready), 64'd1);
    check("reset rd_busy", 64'(rd_busy), 64'd0);
    tick();

    // Bypass then commit
    drive(5, 0, 2'b01, 5, 0, 64'hDEAD_BEEF, '0, 1'b0, 0);
    check("bypass x5", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
    tick();
    drive(5, 2, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    check("commit x5", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
    tick();

    // Port priority
    drive(7, 7, 2'b11, 7, 7, 64'd1, 64'd2, 1'b0, 0);
    check("prio bypass p0", rd_data[0 +: XLEN], 64'd2);
    check("prio bypass p1", rd_data[XLEN +: XLEN], 64'd2);
    tick();
    drive(7, 5, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    check("prio commit", rd_data[0 +: XLEN], 64'd2);
    tick();

    // x0 handling
    drive(0, 0, 2'b01, 0, 0, 64'hFF, '0, 1'b1, 0);
    check("x0 bypass", rd_data[0 +: XLEN], 64'd0);
    check("x0 ready", 64'(iss_ready), 64'd1);
    tick();
    drive(0, 0, 2'b00, 0, 0, '0, '0, 1'b1, 0);
    check("x0 stored", rd_data[0 +: XLEN], 64'd0);
    check("x0 busy", 64'(busy_vec[0]), 64'd0);
    tick();

    // Scoreboard cycle on x9
    drive(9, 0, 2'b00, 0, 0, '0, '0, 1'b1, 9);
    check("claim x9 ready", 64'(iss_ready), 64'd1);
    check("claim x9 not yet busy", 64'(rd_busy[0]), 64'd0);
    tick();
    drive(9, 9, 2'b00, 0, 0, '0, '0, 1'b1, 9);
    check("x9 rd_busy", 64'(rd_busy), 64'd3);
    check("x9 busy_vec", 64'(busy_vec[9]), 64'd1);
    check("x9 second claim", 64'(iss_ready), 64'd0);
    tick();
    drive(9, 0, 2'b10, 0, 9, '0, 64'h99, 1'b1, 9);
    check("x9 clr ready", 64'(iss_ready), 64'd1);
    check("x9 clr rd_busy", 64'(rd_busy[0]), 64'd0);
    check("x9 clr bypass", rd_data[0 +: XLEN], 64'h99);
    tick();
    drive(9, 0, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    check("x9 set wins", 64'(busy_vec[9]), 64'd1);
    check("x9 still rd_busy", 64'(rd_busy[0]), 64'd1);
    tick();
    // Write to non-busy x11 while x9 clears
    drive(11, 9, 2'b11, 9, 11, 64'h9A, 64'hB0B, 1'b0, 0);
    check("x9 final clr", 64'(rd_busy[1]), 64'd0);
    tick();
    drive(11, 9, 2'b00, 0, 0, '0, '0, 1'b0, 9);
    check("x9 idle busy_vec", 64'(busy_vec), 64'd0);
    check("x11 commit", rd_data[0 +: XLEN], 64'hB0B);
    tick();

    // Reset mid-flight
    drive(3, 4, 2'b00, 0, 0, '0, '0, 1'b1, 3);
    tick();
    drive(3, 4, 2'b01, 4, 0, 64'h44, '0, 1'b1, 4);
    tick();
    check("pre-rst busy", 64'(busy_vec), 64'h18);
    rst = 1'b1;
    drive(3, 4, 2'b01, 3, 0, 64'h33, '0, 1'b1, 5);
    tick();
    rst = 1'b0;
    drive(3, 4, 2'b00, 0, 0, '0, '0, 1'b0, 3);
    check("rst busy_vec", 64'(busy_vec), 64'd0);
    check("rst x3", rd_data[0 +: XLEN], 64'd0);
    check("rst x4", rd_data[XLEN +: XLEN], 64'd0);
    check("rst ready", 64'(iss_ready), 64'd1);
    tick();
    drive(2, 7, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    check("rst x2", rd_data[0 +: XLEN], 64'd2048);
    check("rst x7", rd_data[XLEN +: XLEN], 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
